control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Microcode sequencer for the 8-bit CPU: consumes the ALU flags (CF, ZF) and the
//  opcode nibble, and drives the control word the ALU and registers obey (SU, FI, E0).
//  A step counter walks each instruction through fetch (T0-T1) and execute (T2-T4).
//  Conditional jumps resolve here from the latched ALU flags. The HLT opcode freezes the sequencer.
// PARAMETERS
//  STEPS      5  micro-steps per instruction, T0..T(STEPS-1); legal range 3..8
//  EARLY_END  1  1 = restart at T0 after an opcode's last active step; 0 = always run all STEPS
// PORTS
//  CLK    in   1  system clock; all state changes on the rising edge
//  CLR    in   1  asynchronous, active-high reset
//  INSTR  in   4  opcode, which is IR[7:4]
//  CF     in   1  latched ALU carry flag
//  ZF     in   1  latched ALU zero flag
//  STEP   out  3  current micro-step number
//  HLT    out  1  halted indicator; also stops the clock gate
//  MI RI RO IO II AI AO BI OI CE CO J  out  1 each  active-high register/PC controls
//  SU     out  1  ALU subtract select (1 = A-B)
//  E0     out  1  ALU bus output enable, active-LOW
//  FI     out  1  ALU flag-latch enable, active-LOW
// BEHAVIOUR
//  - State is STEP[2:0] plus a halted bit. The control word is combinational from STEP, INSTR, CF and ZF.
//  - Reset (CLR=1, asynchronous) sets STEP=0 and clears halted. The reset word is all
//    active-high outputs 0, with E0=1 and FI=1. Releasing reset starts fetch at T0 on the next edge.
//  - Fetch, same for all opcodes:
//      T0: CO MI
//      T1: RO II CE
//  - Execute steps. Any step not listed below has an empty word.
//      0000 NOP  : none
//      0001 LDA  : T2 IO MI;  T3 RO AI
//      0010 ADD  : T2 IO MI;  T3 RO BI;  T4 E0=0 AI FI=0, SU=0
//      0011 SUB  : same as ADD, but SU=1 throughout T4
//      0100 STA  : T2 IO MI;  T3 AO RI
//      0101 LDI  : T2 IO AI
//      0110 JMP  : T2 IO J
//      0111 JC   : T2 IO J, only if CF=1 at T2
//      1000 JZ   : T2 IO J, only if ZF=1 at T2
//      1110 OUT  : T2 AO OI
//      1111 HLT  : T2 HLT
//      Any other opcode decodes as NOP.
//  - Step advance on each rising edge while not halted:
//      STEP <= STEP+1, wrapping to 0 after STEPS-1.
//      With EARLY_END=1, STEP <= 0 after the opcode's last non-empty step.
//      The last non-empty steps are: LDA/STA T3; ADD/SUB T4; LDI/JMP/JC/JZ/OUT T2.
//      NOP ends after T1. A not-taken JC/JZ still ends at T2.
//  - HLT: at the edge ending T2 of opcode 1111, halted is set and STEP holds at 2.
//    HLT output stays 1 and every other output holds its reset/idle level. Only CLR exits halt.
//  - Flags are sampled combinationally during T2. A flag change mid-T2 changes J in the same cycle.
//    FI and E0 are never asserted together outside T4 of ADD/SUB.
//  - STEP never exceeds STEPS-1, for any INSTR sequence including X-free opcode changes mid-instruction.
//    A mid-instruction INSTR change takes effect combinationally and does not reset STEP.
//  - CLR asserted mid-instruction returns to T0 immediately and drops every pending control.
// TESTING
//  1. Reset then LDI: CLR pulse, INSTR=0101, 3 clocks
//     -> T0 {CO,MI}, T1 {RO,II,CE}, T2 {IO,AI}, next edge STEP=0; E0=FI=1 throughout.
//  2. ADD vs SUB at T4: INSTR=0010 at STEP=4 -> E0=0, FI=0, AI=1, SU=0.
//     Repeat with INSTR=0011 -> SU=1. Both return STEP=0 next edge.
//  3. JC/JZ gating: JC with CF=0 -> J=0 at T2, STEP=0 next. With CF=1 -> J=1, IO=1.
//     JZ likewise against ZF=1/0.
//  4. HLT: INSTR=1111 -> HLT=1 from T2. Then 10 clocks -> STEP stays 2, HLT=1.
//     CLR -> STEP=0, HLT=0 asynchronously, before the next edge.
//  5. Async reset mid-ADD: assert CLR between edges at STEP=3
//     -> STEP=0, BI/RO drop and E0=FI=1 within the same cycle.
//  6. EARLY_END=0 with INSTR=0000: STEP walks 0,1,2,3,4,0; T2-T4 words are empty.
//     An undefined opcode 1010 behaves identically.

Source files
------------

// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit CPU: a micro-step counter plus a halt bit.
// It decodes the opcode, the ALU flags and the current step into the control word.
module control_sequencer #(
  parameter int STEPS     = 5,
  parameter int EARLY_END = 1
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic [3:0] instr_i,
  input  logic       cf_i,
  input  logic       zf_i,
  output logic [2:0] step_o,
  output logic       hlt_o,
  output logic       mi_o,
  output logic       ri_o,
  output logic       ro_o,
  output logic       io_o,
  output logic       ii_o,
  output logic       ai_o,
  output logic       ao_o,
  output logic       bi_o,
  output logic       oi_o,
  output logic       ce_o,
  output logic       co_o,
  output logic       j_o,
  output logic       su_o,
  output logic       e0_o,
  output logic       fi_o
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  logic [2:0] step_q, step_d;
  logic       halted_q, halted_d;

  // Last step that carries a non-empty word; undefined opcodes end with the fetch.
  function automatic logic [2:0] last_active(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA:                             last_active = 3'd3;
      OP_ADD, OP_SUB:                             last_active = 3'd4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_active = 3'd2;
      OP_NOP:                                     last_active = 3'd1;
      default:                                    last_active = 3'd1;
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Comparisons use >= so a mid-instruction opcode change can never push STEP past its bound.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (step_q == 3'd2 && instr_i == OP_HLT) begin
        halted_d = 1'b1;
      end else if (step_q >= LAST_STEP) begin
        step_d = 3'd0;
      end else if (EARLY_END != 0 && step_q >= last_active(instr_i)) begin
        step_d = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_comb begin
    step_o = step_q;
    hlt_o  = 1'b0;
    mi_o   = 1'b0;
    ri_o   = 1'b0;
    ro_o   = 1'b0;
    io_o   = 1'b0;
    ii_o   = 1'b0;
    ai_o   = 1'b0;
    ao_o   = 1'b0;
    bi_o   = 1'b0;
    oi_o   = 1'b0;
    ce_o   = 1'b0;
    co_o   = 1'b0;
    j_o    = 1'b0;
    su_o   = 1'b0;
    e0_o   = 1'b1;
    fi_o   = 1'b1;
    // Reset masks the word combinationally so pending controls drop before the edge.
    if (clr_i) begin
      hlt_o = 1'b0;
    end else if (halted_q) begin
      hlt_o = 1'b1;
    end else begin
      case (step_q)
        3'd0: begin
          co_o = 1'b1;
          mi_o = 1'b1;
        end
        3'd1: begin
          ro_o = 1'b1;
          ii_o = 1'b1;
          ce_o = 1'b1;
        end
        3'd2: begin
          case (instr_i)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              io_o = 1'b1;
              mi_o = 1'b1;
            end
            OP_LDI: begin
              io_o = 1'b1;
              ai_o = 1'b1;
            end
            OP_JMP: begin
              io_o = 1'b1;
              j_o  = 1'b1;
            end
            OP_JC: begin
              io_o = cf_i;
              j_o  = cf_i;
            end
            OP_JZ: begin
              io_o = zf_i;
              j_o  = zf_i;
            end
            OP_OUT: begin
              ao_o = 1'b1;
              oi_o = 1'b1;
            end
            OP_HLT:  hlt_o = 1'b1;
            default: hlt_o = 1'b0;
          endcase
        end
        3'd3: begin
          case (instr_i)
            OP_LDA: begin
              ro_o = 1'b1;
              ai_o = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ro_o = 1'b1;
              bi_o = 1'b1;
            end
            OP_STA: begin
              ao_o = 1'b1;
              ri_o = 1'b1;
            end
            default: ro_o = 1'b0;
          endcase
        end
        3'd4: begin
          if (instr_i == OP_ADD || instr_i == OP_SUB) begin
            e0_o = 1'b0;
            fi_o = 1'b0;
            ai_o = 1'b1;
            su_o = (instr_i == OP_SUB);
          end
        end
        default: hlt_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: an EARLY_END=1 instance for most steps and
// an EARLY_END=0 instance for the full-length walk.
module tb_control_sequencer;

  localparam logic [15:0] W_HLT = 16'h8000;
  localparam logic [15:0] W_MI  = 16'h4000;
  localparam logic [15:0] W_RI  = 16'h2000;
  localparam logic [15:0] W_RO  = 16'h1000;
  localparam logic [15:0] W_IO  = 16'h0800;
  localparam logic [15:0] W_II  = 16'h0400;
  localparam logic [15:0] W_AI  = 16'h0200;
  localparam logic [15:0] W_AO  = 16'h0100;
  localparam logic [15:0] W_BI  = 16'h0080;
  localparam logic [15:0] W_OI  = 16'h0040;
  localparam logic [15:0] W_CE  = 16'h0020;
  localparam logic [15:0] W_CO  = 16'h0010;
  localparam logic [15:0] W_J   = 16'h0008;
  localparam logic [15:0] W_SU  = 16'h0004;
  localparam logic [15:0] W_E0  = 16'h0002;
  localparam logic [15:0] W_FI  = 16'h0001;
  localparam logic [15:0] IDLE  = W_E0 | W_FI;

  logic       clk = 1'b0;
  logic       clr, cf, zf;
  logic [3:0] instr;
  logic [2:0] step;
  logic hlt, mi, ri, ro, io, ii, ai, ao, bi, oi, ce, co, j, su, e0, fi;

  logic       clr2;
  logic [3:0] instr2;
  logic [2:0] step2;
  logic hlt2, mi2, ri2, ro2, io2, ii2, ai2, ao2, bi2, oi2, ce2, co2, j2, su2, e02, fi2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_sequencer #(.STEPS(5), .EARLY_END(1)) u_dut (
    .clk_i(clk), .clr_i(clr), .instr_i(instr), .cf_i(cf), .zf_i(zf), .step_o(step),
    .hlt_o(hlt), .mi_o(mi), .ri_o(ri), .ro_o(ro), .io_o(io), .ii_o(ii), .ai_o(ai),
    .ao_o(ao), .bi_o(bi), .oi_o(oi), .ce_o(ce), .co_o(co), .j_o(j), .su_o(su),
    .e0_o(e0), .fi_o(fi)
  );

  control_sequencer #(.STEPS(5), .EARLY_END(0)) u_dut_full (
    .clk_i(clk), .clr_i(clr2), .instr_i(instr2), .cf_i(cf), .zf_i(zf), .step_o(step2),
    .hlt_o(hlt2), .mi_o(mi2), .ri_o(ri2), .ro_o(ro2), .io_o(io2), .ii_o(ii2), .ai_o(ai2),
    .ao_o(ao2), .bi_o(bi2), .oi_o(oi2), .ce_o(ce2), .co_o(co2), .j_o(j2), .su_o(su2),
    .e0_o(e02), .fi_o(fi2)
  );

  function automatic logic [15:0] word1();
    return {hlt, mi, ri, ro, io, ii, ai, ao, bi, oi, ce, co, j, su, e0, fi};
  endfunction

  function automatic logic [15:0] word2();
    return {hlt2, mi2, ri2, ro2, io2, ii2, ai2, ao2, bi2, oi2, ce2, co2, j2, su2, e02, fi2};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [2:0] exp_step, input logic [15:0] exp_word);
    chk({tag, " step"}, {13'd0, step}, {13'd0, exp_step});
    chk({tag, " word"}, word1(), exp_word);
  endtask

  task automatic chk2(input string tag, input logic [2:0] exp_step, input logic [15:0] exp_word);
    chk({tag, " step"}, {13'd0, step2}, {13'd0, exp_step});
    chk({tag, " word"}, word2(), exp_word);
  endtask

  initial begin
    clr = 1'b1; clr2 = 1'b1; instr = 4'b0101; instr2 = 4'b0000; cf = 1'b0; zf = 1'b0;
    #2;
    chk1("reset", 3'd0, IDLE);
    #1 clr = 1'b0;
    #1;
    // LDI: fetch, one execute step, then early end
    chk1("ldi t0", 3'd0, W_CO | W_MI | IDLE);
    tick(); chk1("ldi t1", 3'd1, W_RO | W_II | W_CE | IDLE);
    tick(); chk1("ldi t2", 3'd2, W_IO | W_AI | IDLE);
    tick(); chk1("ldi end", 3'd0, W_CO | W_MI | IDLE);

    instr = 4'b0010;
    tick(); tick(); chk1("add t2", 3'd2, W_IO | W_MI | IDLE);
    tick(); chk1("add t3", 3'd3, W_RO | W_BI | IDLE);
    tick(); chk1("add t4", 3'd4, W_AI);
    tick(); chk1("add end", 3'd0, W_CO | W_MI | IDLE);

    instr = 4'b0011;
    tick(); tick(); tick(); tick(); chk1("sub t4", 3'd4, W_AI | W_SU);
    tick(); chk1("sub end", 3'd0, W_CO | W_MI | IDLE);

    instr = 4'b0001;
    tick(); tick(); chk1("lda t2", 3'd2, W_IO | W_MI | IDLE);
    tick(); chk1("lda t3", 3'd3, W_RO | W_AI | IDLE);
    tick(); chk1("lda end", 3'd0, W_CO | W_MI | IDLE);

    instr = 4'b0100;
    tick(); tick(); tick(); chk1("sta t3", 3'd3, W_AO | W_RI | IDLE);
    tick(); chk1("sta end", 3'd0, W_CO | W_MI | IDLE);

    instr = 4'b1110;
    tick(); tick(); chk1("out t2", 3'd2, W_AO | W_OI | IDLE);
    tick(); chk1("out end", 3'd0, W_CO | W_MI | IDLE);

    instr = 4'b0000;
    tick(); chk1("nop t1", 3'd1, W_RO | W_II | W_CE | IDLE);
    tick(); chk1("nop end", 3'd0, W_CO | W_MI | IDLE);

    // JC not taken, then taken with a flag drop inside T2
    instr = 4'b0111; cf = 1'b0;
    tick(); tick(); chk1("jc nt t2", 3'd2, IDLE);
    tick(); chk1("jc nt end", 3'd0, W_CO | W_MI | IDLE);
    cf = 1'b1;
    tick(); tick(); chk1("jc t2", 3'd2, W_IO | W_J | IDLE);
    cf = 1'b0; #1;
    chk1("jc cf drop", 3'd2, IDLE);
    tick(); chk1("jc end", 3'd0, W_CO | W_MI | IDLE);

    instr = 4'b1000; zf = 1'b1; cf = 1'b1;
    tick(); tick(); chk1("jz t2", 3'd2, W_IO | W_J | IDLE);
    tick(); zf = 1'b0;
    tick(); tick(); chk1("jz nt t2", 3'd2, IDLE);
    tick(); chk1("jz nt end", 3'd0, W_CO | W_MI | IDLE);
    cf = 1'b0;

    // opcode swapped from ADD to LDI at T3 ends the instruction at once
    instr = 4'b0010;
    tick(); tick(); tick(); instr = 4'b0101; #1;
    chk1("swap t3", 3'd3, IDLE);
    tick(); chk1("swap end", 3'd0, W_CO | W_MI | IDLE);

    instr = 4'b1111;
    tick(); tick(); chk1("hlt t2", 3'd2, W_HLT | IDLE);
    tick(); chk1("hlt latched", 3'd2, W_HLT | IDLE);
    instr = 4'b0010;
    for (int k = 0; k < 10; k++) tick();
    chk1("hlt hold", 3'd2, W_HLT | IDLE);
    #2 clr = 1'b1;
    #1 chk1("hlt clr", 3'd0, IDLE);
    #1 clr = 1'b0;

    // async reset mid-ADD at T3
    tick(); tick(); tick(); chk1("add2 t3", 3'd3, W_RO | W_BI | IDLE);
    #2 clr = 1'b1;
    #1 chk1("mid clr", 3'd0, IDLE);
    #1 clr = 1'b0;
    #1 chk1("mid rel", 3'd0, W_CO | W_MI | IDLE);
    tick(); chk1("mid t1", 3'd1, W_RO | W_II | W_CE | IDLE);

    // EARLY_END=0: NOP and undefined opcode both walk all five steps
    #2 clr2 = 1'b0;
    for (int p = 0; p < 2; p++) begin
      instr2 = (p == 0) ? 4'b0000 : 4'b1010;
      #1;
      chk2("full t0", 3'd0, W_CO | W_MI | IDLE);
      tick(); chk2("full t1", 3'd1, W_RO | W_II | W_CE | IDLE);
      tick(); chk2("full t2", 3'd2, IDLE);
      tick(); chk2("full t3", 3'd3, IDLE);
      tick(); chk2("full t4", 3'd4, IDLE);
      tick(); chk2("full wrap", 3'd0, W_CO | W_MI | IDLE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
